// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_ctrl_pkg;

    // Round counts for the three AES key sizes
    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    // Round index width wide enough for the largest round count
    localparam int RW_DEFAULT = 4;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: handshakes a start request, pulses the initial
// AddRoundKey load, steps the round index 1..NR, strobes result capture
// and holds done until acknowledged. All outputs are registered Moore
// outputs, so nothing combinational runs from ld/ack to any output.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR = AES128_NR,
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    output logic          ready,
    output logic          ld_r,
    output logic          kld,
    output logic [RW-1:0] rnd,
    output logic          final_rnd,
    output logic          out_we,
    output logic          done,
    input  logic          ack
);

    // Reject unsupported round counts and too-narrow round index widths
    generate
        if (!(NR == AES128_NR || NR == AES192_NR || NR == AES256_NR)) begin : g_bad_nr
            $error("aes_round_ctrl: NR must be 10, 12 or 14");
        end
        if ((2 ** RW) <= NR) begin : g_bad_rw
            $error("aes_round_ctrl: RW too narrow for NR");
        end
    endgenerate

    localparam logic [RW-1:0] NR_V = RW'(NR);

    state_e        state_q;
    logic [RW-1:0] rnd_q;
    logic [RW-1:0] rnd_inc;
    logic          ready_q;
    logic          ld_r_q;
    logic          kld_q;
    logic          final_q;
    logic          out_we_q;
    logic          done_q;

    assign rnd_inc = rnd_q + RW'(1);

    // Sequencer FSM; outputs are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rnd_q    <= '0;
            ready_q  <= 1'b1;
            ld_r_q   <= 1'b0;
            kld_q    <= 1'b0;
            final_q  <= 1'b0;
            out_we_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ld) begin
                        state_q <= S_LOAD;
                        ready_q <= 1'b0;
                        ld_r_q  <= 1'b1;
                        kld_q   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q <= S_ROUND;
                    ld_r_q  <= 1'b0;
                    kld_q   <= 1'b0;
                    rnd_q   <= RW'(1);
                    final_q <= (NR_V == RW'(1));
                end
                S_ROUND: begin
                    if (rnd_q == NR_V) begin
                        // rnd holds at NR through OUT and DONE; it never wraps
                        state_q  <= S_OUT;
                        final_q  <= 1'b0;
                        out_we_q <= 1'b1;
                    end else begin
                        rnd_q   <= rnd_inc;
                        final_q <= (rnd_inc == NR_V);
                    end
                end
                S_OUT: begin
                    state_q  <= S_DONE;
                    out_we_q <= 1'b0;
                    done_q   <= 1'b1;
                end
                S_DONE: begin
                    if (ack) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                        rnd_q   <= '0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    rnd_q    <= '0;
                    ready_q  <= 1'b1;
                    ld_r_q   <= 1'b0;
                    kld_q    <= 1'b0;
                    final_q  <= 1'b0;
                    out_we_q <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign ld_r      = ld_r_q;
    assign kld       = kld_q;
    assign rnd       = rnd_q;
    assign final_rnd = final_q;
    assign out_we    = out_we_q;
    assign done      = done_q;

endmodule
